// File: rtl/sr_mem_arb_if.sv
// Requester-side bus of sr_mem_arb: one instance per master (CPU or debug loader).
// The master drives the request fields; the arbiter answers with gnt/rvalid/rdata.
interface sr_mem_arb_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sr_mem_arb.sv
// Two-master round-robin arbiter in front of a single-port synchronous memory.
// Supports a bounded bus lock for bursts and steers 1-cycle read responses back
// to the master that issued the read.
module sr_mem_arb #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    sr_mem_arb_if.slave   m0,
    sr_mem_arb_if.slave   m1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    state_t     state, stateNext;
    logic       rrPtr, rrPtrNext;     // last granted master
    logic [7:0] lockCnt, lockCntNext;
    logic       respValid, respId;

    logic [1:0] req, lock, we, gnt;
    logic       owned, owner, exitOwn, arbCycle, ptrEff, winner, sel;

    assign req  = {m1.req,  m0.req};
    assign lock = {m1.lock, m0.lock};
    assign we   = {m1.we,   m0.we};

    // Arbitration, lock bookkeeping and next-state selection.
    always_comb begin
        gnt         = '0;
        stateNext   = state;
        rrPtrNext   = rrPtr;
        lockCntNext = lockCnt;
        owned       = (state != ARB);
        owner       = (state == OWN1);
        exitOwn     = 1'b0;
        ptrEff      = rrPtr;
        winner      = 1'b0;

        // Owner lets go voluntarily, or is forced out once the lock has run
        // its course and the other master is actually waiting.
        if (owned)
            exitOwn = !lock[owner] || (lockCnt == LOCK_LIMIT && req[!owner]);
        arbCycle = !owned || exitOwn;
        // Pretend the owner was granted last so a waiting master wins the tie.
        if (exitOwn)
            ptrEff = owner;

        if (arbCycle) begin
            winner      = (req == 2'b11) ? !ptrEff : req[1];
            rrPtrNext   = ptrEff;
            stateNext   = ARB;
            lockCntNext = 8'd0;
            if (req != 2'b00) begin
                gnt[winner] = 1'b1;
                rrPtrNext   = winner;
                if (lock[winner]) begin
                    stateNext   = winner ? OWN1 : OWN0;
                    lockCntNext = 8'd1;
                end
            end
        end else begin
            gnt[owner] = req[owner];
            if (lockCnt < LOCK_LIMIT)
                lockCntNext = lockCnt + 8'd1;
        end

        if (rst)
            gnt = '0;
    end

    // Memory port mux: the granted master owns the bus this cycle.
    always_comb begin
        sel       = gnt[1];
        mem_en    = |gnt;
        mem_we    = (|gnt) & we[sel];
        mem_addr  = sel ? m1.addr  : m0.addr;
        mem_wdata = sel ? m1.wdata : m0.wdata;
    end

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    // Gated by rst so a read issued just before reset never returns.
    assign m0.rvalid = respValid & (respId == 1'b0) & !rst;
    assign m1.rvalid = respValid & (respId == 1'b1) & !rst;
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;

    // State, round-robin pointer, lock counter and read-response tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            rrPtr     <= 1'b1;
            lockCnt   <= 8'd0;
            respValid <= 1'b0;
            respId    <= 1'b0;
        end else begin
            state     <= stateNext;
            rrPtr     <= rrPtrNext;
            lockCnt   <= lockCntNext;
            respValid <= mem_en & !mem_we;
            if (mem_en)
                respId <= sel;
        end
    end
endmodule

// File: tb/tb_sr_mem_arb.sv
// Self-checking bench for sr_mem_arb with a behavioural 1-cycle-latency memory
// and a read-response scoreboard.
module tb_sr_mem_arb;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_mem_arb_if #(.AW(AW), .DW(DW)) m0If ();
    sr_mem_arb_if #(.AW(AW), .DW(DW)) m1If ();

    logic          memEn, memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata = '0;

    sr_mem_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst), .m0(m0If), .m1(m1If),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_rdata(memRdata)
    );

    logic [DW-1:0] mem    [256];
    logic [DW-1:0] refMem [256];

    // Single-port synchronous memory, read data one cycle after the access.
    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) mem[memAddr] = memWdata;
            else       memRdata <= mem[memAddr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } resp_t;
    resp_t q[$];

    int checks = 0, failures = 0, monChecks = 0, monFails = 0;

    // Scoreboard: grants observed at the master side push expected responses,
    // rvalid pops and compares id, data and arrival cycle.
    always @(negedge clk) begin
        resp_t e;
        logic  gotId;
        logic [DW-1:0] gotData;
        if (rst) begin
            monChecks++;
            if (m0If.rvalid !== 1'b0 || m1If.rvalid !== 1'b0) begin
                monFails++;
                $display("FAIL rvalid_in_reset cyc=%0d m0=%b m1=%b want 0 0", cyc, m0If.rvalid, m1If.rvalid);
            end
            q.delete();
        end else begin
            if (m0If.rvalid === 1'b1 || m1If.rvalid === 1'b1) begin
                monChecks++;
                gotId   = m1If.rvalid;
                gotData = gotId ? m1If.rdata : m0If.rdata;
                if (q.size() == 0) begin
                    monFails++;
                    $display("FAIL spurious_rvalid cyc=%0d m0=%b m1=%b want none", cyc, m0If.rvalid, m1If.rvalid);
                end else begin
                    e = q.pop_front();
                    if (e.id !== gotId || e.data !== gotData || e.due != cyc
                        || (m0If.rvalid === 1'b1 && m1If.rvalid === 1'b1)) begin
                        monFails++;
                        $display("FAIL rvalid_resp cyc=%0d got id=%b data=%h want id=%b data=%h due=%0d",
                                 cyc, gotId, gotData, e.id, e.data, e.due);
                    end
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                monChecks++;
                monFails++;
                $display("FAIL missing_rvalid cyc=%0d want id=%b data=%h", cyc, q[0].id, q[0].data);
                void'(q.pop_front());
            end
            if (m0If.gnt === 1'b1) begin
                if (m0If.we) refMem[m0If.addr] = m0If.wdata;
                else q.push_back('{1'b0, refMem[m0If.addr], cyc + 1});
            end
            if (m1If.gnt === 1'b1) begin
                if (m1If.we) refMem[m1If.addr] = m1If.wdata;
                else q.push_back('{1'b1, refMem[m1If.addr], cyc + 1});
            end
        end
    end

    task automatic drv0(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m0If.req = req; m0If.we = we; m0If.lock = lock; m0If.addr = addr; m0If.wdata = wdata;
    endtask

    task automatic drv1(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m1If.req = req; m1If.we = we; m1If.lock = lock; m1If.addr = addr; m1If.wdata = wdata;
    endtask

    task automatic idle();
        drv0(0, 0, 0, '0, '0);
        drv1(0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        drv0(1, 0, 0, 8'h10, '0);
        drv1(1, 1, 1, 8'h20, 32'h1234);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m1If.gnt, m0If.gnt, memEn, memWe} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs gnt=%b%b en=%b we=%b want all 0", m1If.gnt, m0If.gnt, memEn, memWe);
            end
        end
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
    endtask

    task automatic test_tie();
        logic [1:0] want;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drv0(1, 0, 0, 8'h10, '0);
            drv1(1, 0, 0, 8'h20, '0);
            @(negedge clk);
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({m1If.gnt, m0If.gnt} !== want) begin
                failures++;
                $display("FAIL tie_gnt step=%0d got %b want %b", i, {m1If.gnt, m0If.gnt}, want);
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_write_read();
        logic m1Seen = 1'b0;
        @(posedge clk); #1;
        drv1(1, 1, 0, 8'h05, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({m1If.gnt, m0If.gnt, memWe} !== 3'b101) begin
            failures++;
            $display("FAIL wr_gnt got gnt=%b we=%b want 10 1", {m1If.gnt, m0If.gnt}, memWe);
        end
        @(posedge clk); #1;
        drv1(0, 0, 0, '0, '0);
        drv0(1, 0, 0, 8'h05, '0);
        @(negedge clk);
        m1Seen |= m1If.rvalid;
        checks++;
        if ({m1If.gnt, m0If.gnt} !== 2'b01) begin
            failures++;
            $display("FAIL rd_gnt got %b want 01", {m1If.gnt, m0If.gnt});
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        m1Seen |= m1If.rvalid;
        checks++;
        if (m0If.rvalid !== 1'b1 || m0If.rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_data got rvalid=%b rdata=%h want 1 deadbeef", m0If.rvalid, m0If.rdata);
        end
        @(negedge clk);
        m1Seen |= m1If.rvalid;
        checks++;
        if (m1Seen !== 1'b0) begin
            failures++;
            $display("FAIL m1_rvalid_after_write got 1 want 0");
        end
    endtask

    task automatic test_locked_burst();
        logic [1:0] want;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i < 4) drv1(1, 1, 1, 8'h30 + 8'(i), 32'hB0B0_0000 + 32'(i));
            else       drv1(0, 0, 0, '0, '0);
            if (i == 0)      drv0(0, 0, 0, '0, '0);
            else if (i < 5)  drv0(1, 0, 0, 8'h40, '0);
            else             drv0(1, 0, 0, 8'h33, '0);
            @(negedge clk);
            want = (i < 4) ? 2'b10 : 2'b01;
            checks++;
            if ({m1If.gnt, m0If.gnt} !== want) begin
                failures++;
                $display("FAIL burst_gnt step=%0d got %b want %b", i, {m1If.gnt, m0If.gnt}, want);
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_timeout();
        logic [1:0] want;
        // Contested lock: timeout at lock_cnt == LOCK_MAX.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (i < 6) drv1(1, 0, 1, 8'h50, '0);
            else       drv1(0, 0, 0, '0, '0);
            if (i >= 1 && i <= 4) drv0(1, 0, 0, 8'h60, '0);
            else                  drv0(0, 0, 0, '0, '0);
            @(negedge clk);
            case (i)
                4:       want = 2'b01;
                6:       want = 2'b00;
                default: want = 2'b10;
            endcase
            checks++;
            if ({m1If.gnt, m0If.gnt} !== want) begin
                failures++;
                $display("FAIL timeout_gnt step=%0d got %b want %b", i, {m1If.gnt, m0If.gnt}, want);
            end
        end
        // Lone locked owner keeps the bus past LOCK_MAX until someone waits.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i < 8) drv1(1, 0, 1, 8'h51, '0);
            else       drv1(0, 0, 0, '0, '0);
            if (i == 7) drv0(1, 0, 0, 8'h61, '0);
            else        drv0(0, 0, 0, '0, '0);
            @(negedge clk);
            want = (i == 7) ? 2'b01 : (i == 8) ? 2'b00 : 2'b10;
            checks++;
            if ({m1If.gnt, m0If.gnt} !== want) begin
                failures++;
                $display("FAIL lone_lock_gnt step=%0d got %b want %b", i, {m1If.gnt, m0If.gnt}, want);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        drv0(1, 0, 0, 8'h10, '0);
        @(negedge clk);
        checks++;
        if (m0If.gnt !== 1'b1) begin
            failures++;
            $display("FAIL midrd_gnt got %b want 1", m0If.gnt);
        end
        @(posedge clk); #1;
        idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m0If.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL midrd_rvalid_in_reset got %b want 0", m0If.rvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drv0(1, 0, 0, 8'h10, '0);
        drv1(1, 0, 0, 8'h20, '0);
        @(negedge clk);
        checks++;
        if ({m1If.gnt, m0If.gnt, m0If.rvalid} !== 3'b010) begin
            failures++;
            $display("FAIL post_reset_tie got gnt=%b rvalid=%b want 01 0", {m1If.gnt, m0If.gnt}, m0If.rvalid);
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            idle();
            @(negedge clk);
            if (i == 0) continue;  // first cycle still carries the last read's response
            checks++;
            if ({memEn, m0If.gnt, m1If.gnt, m0If.rvalid, m1If.rvalid} !== 5'b00000) begin
                failures++;
                $display("FAIL idle step=%0d en=%b gnt=%b%b rvalid=%b%b want all 0",
                         i, memEn, m1If.gnt, m0If.gnt, m1If.rvalid, m0If.rvalid);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0103);
            refMem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0103);
        end
        idle();
        test_reset();
        test_tie();
        test_write_read();
        test_locked_burst();
        test_timeout();
        test_reset_mid_read();
        test_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        checks   += monChecks;
        failures += monFails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sr_mem_arb.md
# sr_mem_arb

Two-requester arbiter that shares one single-port synchronous memory (1-cycle read latency) between the CPU fetch/data path (master 0) and a debug/program-loader port (master 1). It performs round-robin arbitration, supports a bounded bus lock for multi-word bursts, and routes read responses back to the master that issued them. It sits between the core's memory ports and the memory macro.

## Interface

Parameters:
- AW, 8: memory word-address width.
- DW, 32: data width.
- LOCK_MAX, 16: maximum lock cycles before a waiting master forces handover; legal range 2..255.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- m0_req, m1_req  in  1  request; held with addr/we/wdata stable until gnt.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_lock, m1_lock  in  1  request to keep ownership after this grant.
- m0_addr, m1_addr  in  AW  word address.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  out  1  read data valid (registered).
- m0_rdata, m1_rdata  out  DW  read data; both driven from mem_rdata.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after a read access.

## Operation

- States: ARB (no owner), OWN0, OWN1. Registers: state, rr_ptr (last granted master), lock_cnt (8 bits, saturating), resp_valid, resp_id.
- Arbitration cycle (state ARB, or exit condition in OWNn): one requester gets the grant; if both request, the grant goes to the master that is not rr_ptr. rr_ptr updates to the granted master.
- In OWNn: only master n can be granted (when m<n>_req = 1); the other master is held off.
- OWNn exit condition: m<n>_lock = 0, or (lock_cnt == LOCK_MAX and the other master requests). On exit the same cycle is an arbitration cycle with rr_ptr forced to n, so a waiting master wins.
- Entering ownership: when master n is granted in an arbitration cycle with m<n>_lock = 1, the next state is OWNn with lock_cnt = 1. Otherwise the next state is ARB.
- While in OWNn without exit: lock_cnt increments every cycle, saturating at LOCK_MAX.
- Granted master drives mem_en = 1, mem_we = m<n>_we, mem_addr, and mem_wdata. With no grant, mem_en = 0 and mem_we = 0; mem_addr and mem_wdata are don't-care.
- Response tracking: a granted read sets resp_valid = 1 and resp_id = n for the next cycle. A granted write sets resp_valid = 0. m<n>_rvalid = resp_valid & (resp_id == n).
- Back-to-back reads from either master are allowed, one per cycle. A response never blocks a new grant.

## Timing

- Grant latency: 0 cycles; gnt is asserted in the same cycle as req when the master wins.
- Read data latency: m<n>_rvalid is asserted exactly 1 cycle after the m<n>_gnt cycle of a read.
- Write latency: the memory is updated at the clock edge ending the gnt cycle.
- Reset (rst = 1 sampled at an edge) sets: state = ARB, rr_ptr = 1 (master 0 wins the first tie), lock_cnt = 0, resp_valid = 0.
- While rst = 1, all gnt outputs, mem_en, and mem_we are forced to 0 combinationally, and no access is issued.
- Reset mid-burst or mid-read: ownership is dropped, and a pending rvalid is suppressed (no rvalid in the cycle after reset).
- Simultaneous events:
  - If the owner drops lock in the same cycle the other master requests, the other master is granted that cycle.
  - If the owner drops lock and no other master requests, the owner may still be granted that cycle as a normal unlocked access.
- The lock timeout only fires while the other master is requesting. A lone locked owner keeps the bus indefinitely.

## Test plan

- Tie after reset: m0_req = m1_req = 1 (reads, addr 0x10 and 0x20) held for 4 cycles.
  - Grants alternate m0, m1, m0, m1.
  - Each m<n>_rvalid follows its grant by 1 cycle, with rdata = mem[0x10] or mem[0x20].
- Write then read: m1 writes 0xDEADBEEF to 0x05, then m0 reads 0x05.
  - m0_rvalid arrives 1 cycle after its grant with rdata = 0xDEADBEEF.
  - m1_rvalid is never asserted.
- Locked burst: m1 locks and issues 4 writes while m0_req = 1.
  - m0 receives no grant until m1_lock drops.
  - m0 is granted in the cycle m1_lock = 0.
- Lock timeout with LOCK_MAX = 4: m1 holds lock and req continuously while m0 requests.
  - m0 is granted in the cycle lock_cnt == 4.
  - m1 is granted again no earlier than the next cycle.
- Reset mid-read: m0 is granted a read and rst = 1 on the following cycle.
  - m0_rvalid stays 0.
  - After release: state ARB, first tie goes to m0.
- Idle: no requests for 10 cycles.
  - mem_en = 0, all gnt = 0, all rvalid = 0 throughout.
